ascon_arb: RTL and testbench
============================

# ascon_arb

Arbiter that time-shares one `ascon_core` instance between `NREQ` independent requesters, granting the core for one complete operation at a time. An operation runs from mode start to core `done`. Sits between the requester-side stream interfaces (key/bdi/bdo per requester) and the single core. It handles round-robin selection, full datapath muxing, per-requester latching of the authentication result, and sequencing of the core reset.

## Interface
Parameters:
- `CCW`, 32: core data width (32 or 64); must match the core.
- `NREQ`, 2: number of requesters (2..4).

Ports (requester-side buses are arrays indexed `[NREQ-1:0]`; the listed width is per element):
- `clk`  in  1  single clock for the arbiter and the core.
- `rst_n`  in  1  asynchronous, active-low reset.
- `core_rst`  out  1  active-high reset to the core.
- `req_mode`  in  4  requested mode; nonzero = request.
- `req_key`, `req_key_valid` / `req_key_ready`  in CCW,1 / out 1  key stream.
- `req_bdi`, `req_bdi_valid`, `req_bdi_type`, `req_bdi_eot`, `req_bdi_eoi`  in  CCW, CCW/8, 4, 1, 1  input stream.
- `req_bdi_ready`  out  1
- `req_bdo`, `req_bdo_valid`, `req_bdo_type`, `req_bdo_eot`  out  CCW, 1, 4, 1  output stream.
- `req_bdo_ready`, `req_bdo_eoo`  in  1, 1
- `req_auth`, `req_auth_valid`  out  1, 1  latched tag-verify result.
- `req_done`  out  1  one-cycle end-of-operation pulse.
- `gnt`  out  NREQ  one-hot current grant (0 when idle).
- `core_*`  mirrors every `ascon_core` port with the opposite direction (`core_key`, `core_key_valid`, `core_key_ready`, `core_bdi*`, `core_mode`, `core_bdo*`, `core_auth`, `core_auth_valid`, `core_done`).

## Operation
- FSM states: `RST_HOLD`, `IDLE`, `START`, `BUSY`, `RELEASE`.
- `RST_HOLD`: entered asynchronously on `rst_n`=0.
  - `core_rst`=1 while `rst_n`=0 and for 2 cycles after `rst_n` rises (2-flop synchronizer).
  - Go to `IDLE` the cycle `core_rst` falls.
- `IDLE`:
  - Requester i is eligible if `req_mode[i]`!=0 and i is not masked.
  - Pick the first eligible index at or after `rr_ptr`, wrapping modulo `NREQ`.
  - On a pick: register `gnt`, go to `START`. No eligible requester: stay.
- `START` (exactly 1 cycle):
  - All core inputs are forwarded from the granted requester, including `core_mode` and `core_bdi_eoi`, which the core samples now.
  - Clear `req_auth_valid[g]` and `req_auth[g]`.
  - Go to `BUSY`.
- `BUSY`:
  - Full combinational mux in both directions for granted requester g.
  - Non-granted requesters see all ready/valid outputs at 0 and `req_bdo`=0.
  - When `core_done`=1: latch `core_auth`/`core_auth_valid` into `req_auth[g]`/`req_auth_valid[g]`, go to `RELEASE`.
- `RELEASE` (1 cycle):
  - `req_done[g]`=1, `core_mode`=0, all core valids 0.
  - `rr_ptr` <= (g+1) mod `NREQ`.
  - Mask requester g in the next `IDLE` cycle only.
  - `gnt` <= 0; go to `IDLE`.
- Requester obligation: hold `req_mode` stable and nonzero from request until `req_done`, and drop it in the cycle after `req_done`. The arbiter's one-cycle mask covers that cycle.
- Outside `START`/`BUSY`, all core inputs are 0.
- `req_auth_valid[i]` stays high until requester i's next `START`.
- Reset mid-operation: everything returns to reset values asynchronously. The core is reset via `core_rst`. No `req_done` is issued for the aborted operation.

## Timing
- Reset values: `gnt`=0, `req_done`=0, `req_auth`=0, `req_auth_valid`=0, all `req_*_ready`=0, `req_bdo_valid`=0, `req_bdo`=0, all `core_*` outputs 0 except `core_rst`=1, `rr_ptr`=0.
- Grant latency: `req_mode` seen in `IDLE` at cycle t → `START` at t+1 → core leaves idle at t+2.
- `BUSY` starts after the core has cleared its stale `done`, so `done` is never misread.
- Handshakes in `BUSY` are combinational pass-through: zero added latency and no buffering.
- Back-to-back, different requesters: `RELEASE` → `IDLE` → `START`. Minimum gap between operations is 2 idle cycles on the core.
- Simultaneous requests in `IDLE`: the lowest index at or after `rr_ptr` wins.

## Test plan
- Reset: `rst_n` low for 3 cycles then high → all outputs at reset values; `core_rst` falls 2 cycles after `rst_n` rises; FSM reaches `IDLE`.
- Single AEAD encrypt (mode `M_ENC`, 16 B AD, 16 B msg, `CCW`=32) on requester 0 → ciphertext/tag identical to direct-core golden vectors; `req_done[0]` pulses once; `gnt` returns to 0.
- Both requesters assert in the same cycle, then hold → grants alternate 0,1,0,1. No input ever reaches the core from the non-granted side, and non-granted ready/valid stay 0.
- Requester 1 decrypt with a corrupted tag while requester 0 decrypts correctly → `req_auth_valid`=1 on both; `req_auth[0]`=1, `req_auth[1]`=0; each persists until that requester's next `START`.
- `M_HASH` with `bdo_ready` toggled randomly, plus back-to-back `M_XOF` from the same requester → 256-bit digest correct; the mask prevents regrant in the cycle after `req_done`.
- `rst_n` pulsed low mid-`BUSY` → immediate return to reset values, no `req_done`; a subsequent operation completes correctly.

Source files
------------

// File: rtl/ascon_arb.sv
// ascon_arb: time-shares a single ascon_core between NREQ requesters, one complete
// operation (mode start to core done) at a time, with round-robin selection.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   core_rst            active-high core reset, held 2 cycles after rst_n rises
//   req_mode            per-requester mode, nonzero = request
//   req_key*/req_bdi*   per-requester input streams (forwarded when granted)
//   req_bdo*            per-requester output stream (zero unless granted)
//   req_auth*           per-requester latched tag-verify result
//   req_done            one-cycle end-of-operation pulse
//   gnt                 one-hot current grant, 0 when idle
//   core_*              mirror of the ascon_core port list, opposite direction
module ascon_arb #(
    parameter int unsigned CCW  = 32,
    parameter int unsigned NREQ = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           core_rst,
    // requester side
    input  logic [NREQ-1:0][3:0]           req_mode,
    input  logic [NREQ-1:0][CCW-1:0]       req_key,
    input  logic [NREQ-1:0]                req_key_valid,
    output logic [NREQ-1:0]                req_key_ready,
    input  logic [NREQ-1:0][CCW-1:0]       req_bdi,
    input  logic [NREQ-1:0][CCW/8-1:0]     req_bdi_valid,
    input  logic [NREQ-1:0][3:0]           req_bdi_type,
    input  logic [NREQ-1:0]                req_bdi_eot,
    input  logic [NREQ-1:0]                req_bdi_eoi,
    output logic [NREQ-1:0]                req_bdi_ready,
    output logic [NREQ-1:0][CCW-1:0]       req_bdo,
    output logic [NREQ-1:0]                req_bdo_valid,
    output logic [NREQ-1:0][3:0]           req_bdo_type,
    output logic [NREQ-1:0]                req_bdo_eot,
    input  logic [NREQ-1:0]                req_bdo_ready,
    input  logic [NREQ-1:0]                req_bdo_eoo,
    output logic [NREQ-1:0]                req_auth,
    output logic [NREQ-1:0]                req_auth_valid,
    output logic [NREQ-1:0]                req_done,
    output logic [NREQ-1:0]                gnt,
    // core side
    output logic [CCW-1:0]                 core_key,
    output logic                           core_key_valid,
    input  logic                           core_key_ready,
    output logic [CCW-1:0]                 core_bdi,
    output logic [CCW/8-1:0]               core_bdi_valid,
    output logic [3:0]                     core_bdi_type,
    output logic                           core_bdi_eot,
    output logic                           core_bdi_eoi,
    input  logic                           core_bdi_ready,
    output logic [3:0]                     core_mode,
    input  logic [CCW-1:0]                 core_bdo,
    input  logic                           core_bdo_valid,
    input  logic [3:0]                     core_bdo_type,
    input  logic                           core_bdo_eot,
    output logic                           core_bdo_ready,
    output logic                           core_bdo_eoo,
    input  logic                           core_auth,
    input  logic                           core_auth_valid,
    input  logic                           core_done
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        StRstHold,
        StIdle,
        StStart,
        StBusy,
        StRelease
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] mask_q;
    logic [1:0]      sync_q;

    logic [NREQ-1:0] elig;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW:0]     cand_sum;
    logic            fwd;

    // Core stays in reset until the synchronizer has seen rst_n high for 2 edges.
    assign core_rst = ~sync_q[1];

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            elig[i] = (req_mode[i] != 4'd0) && !mask_q[i];
        end
    end

    // Round-robin: first eligible index at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_sum   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IW+1)'(NREQ);
            end
            if (!pick_found && elig[cand_sum[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand_sum[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StRstHold;
            idx_q          <= '0;
            rr_ptr_q       <= '0;
            mask_q         <= '0;
            sync_q         <= 2'b00;
            gnt            <= '0;
            req_done       <= '0;
            req_auth       <= '0;
            req_auth_valid <= '0;
        end else begin
            sync_q   <= {sync_q[0], 1'b1};
            req_done <= '0;
            unique case (state_q)
                StRstHold: begin
                    // Leave on the same edge that drops core_rst.
                    if (sync_q[0]) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    mask_q <= '0;
                    if (pick_found) begin
                        gnt     <= NREQ'(1) << pick_idx;
                        idx_q   <= pick_idx;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    // Core has just sampled mode; its stale done is gone by BUSY.
                    req_auth[idx_q]       <= 1'b0;
                    req_auth_valid[idx_q] <= 1'b0;
                    state_q               <= StBusy;
                end
                StBusy: begin
                    if (core_done) begin
                        req_auth[idx_q]       <= core_auth;
                        req_auth_valid[idx_q] <= core_auth_valid;
                        req_done              <= gnt;
                        state_q               <= StRelease;
                    end
                end
                StRelease: begin
                    rr_ptr_q <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                    // Covers the cycle in which the finished requester drops its mode.
                    mask_q   <= gnt;
                    gnt      <= '0;
                    state_q  <= StIdle;
                end
                default: state_q <= StRstHold;
            endcase
        end
    end

    assign fwd = (state_q == StStart) || (state_q == StBusy);

    // Zero-latency pass-through between the granted requester and the core.
    always_comb begin
        core_key       = '0;
        core_key_valid = 1'b0;
        core_bdi       = '0;
        core_bdi_valid = '0;
        core_bdi_type  = '0;
        core_bdi_eot   = 1'b0;
        core_bdi_eoi   = 1'b0;
        core_mode      = '0;
        core_bdo_ready = 1'b0;
        core_bdo_eoo   = 1'b0;
        req_key_ready  = '0;
        req_bdi_ready  = '0;
        req_bdo        = '0;
        req_bdo_valid  = '0;
        req_bdo_type   = '0;
        req_bdo_eot    = '0;
        if (fwd) begin
            core_key              = req_key[idx_q];
            core_key_valid        = req_key_valid[idx_q];
            core_bdi              = req_bdi[idx_q];
            core_bdi_valid        = req_bdi_valid[idx_q];
            core_bdi_type         = req_bdi_type[idx_q];
            core_bdi_eot          = req_bdi_eot[idx_q];
            core_bdi_eoi          = req_bdi_eoi[idx_q];
            core_mode             = req_mode[idx_q];
            core_bdo_ready        = req_bdo_ready[idx_q];
            core_bdo_eoo          = req_bdo_eoo[idx_q];
            req_key_ready[idx_q]  = core_key_ready;
            req_bdi_ready[idx_q]  = core_bdi_ready;
            req_bdo[idx_q]        = core_bdo;
            req_bdo_valid[idx_q]  = core_bdo_valid;
            req_bdo_type[idx_q]   = core_bdo_type;
            req_bdo_eot[idx_q]    = core_bdo_eot;
        end
    end

endmodule

// File: tb/tb_ascon_arb.sv
// tb_ascon_arb: self-checking bench for ascon_arb with two requesters and a small
// behavioural stand-in for ascon_core (key word, data words, transformed output words,
// tag check in decrypt mode, one-cycle done).
module tb_ascon_arb;

    localparam logic [3:0] M_ENC  = 4'd1;
    localparam logic [3:0] M_DEC  = 4'd2;
    localparam logic [3:0] M_HASH = 4'd3;
    localparam logic [3:0] M_XOF  = 4'd4;
    localparam int         LIM    = 400;

    logic clk, rst_n, core_rst;
    logic [1:0][3:0]  req_mode;
    logic [1:0][31:0] req_key;
    logic [1:0]       req_key_valid, req_key_ready;
    logic [1:0][31:0] req_bdi;
    logic [1:0][3:0]  req_bdi_valid, req_bdi_type;
    logic [1:0]       req_bdi_eot, req_bdi_eoi, req_bdi_ready;
    logic [1:0][31:0] req_bdo;
    logic [1:0]       req_bdo_valid;
    logic [1:0][3:0]  req_bdo_type;
    logic [1:0]       req_bdo_eot, req_bdo_ready, req_bdo_eoo;
    logic [1:0]       req_auth, req_auth_valid, req_done, gnt;
    logic [31:0] core_key, core_bdi, core_bdo;
    logic        core_key_valid, core_key_ready;
    logic [3:0]  core_bdi_valid, core_bdi_type, core_mode, core_bdo_type;
    logic        core_bdi_eot, core_bdi_eoi, core_bdi_ready;
    logic        core_bdo_valid, core_bdo_eot, core_bdo_ready, core_bdo_eoo;
    logic        core_auth, core_auth_valid, core_done;

    int n_cmp = 0, n_bad = 0;
    int iso_bad = 0, leak_bad = 0, mask_bad = 0;
    int done_cnt [2];
    int glog[$];
    logic [32:0] sb0[$], sb1[$];
    logic [32:0] mon_exp;
    logic [1:0]  gprev, dn1, dn2;

    ascon_arb #(.CCW(32), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n), .core_rst(core_rst),
        .req_mode(req_mode), .req_key(req_key), .req_key_valid(req_key_valid),
        .req_key_ready(req_key_ready), .req_bdi(req_bdi), .req_bdi_valid(req_bdi_valid),
        .req_bdi_type(req_bdi_type), .req_bdi_eot(req_bdi_eot), .req_bdi_eoi(req_bdi_eoi),
        .req_bdi_ready(req_bdi_ready), .req_bdo(req_bdo), .req_bdo_valid(req_bdo_valid),
        .req_bdo_type(req_bdo_type), .req_bdo_eot(req_bdo_eot),
        .req_bdo_ready(req_bdo_ready), .req_bdo_eoo(req_bdo_eoo), .req_auth(req_auth),
        .req_auth_valid(req_auth_valid), .req_done(req_done), .gnt(gnt),
        .core_key(core_key), .core_key_valid(core_key_valid),
        .core_key_ready(core_key_ready), .core_bdi(core_bdi),
        .core_bdi_valid(core_bdi_valid), .core_bdi_type(core_bdi_type),
        .core_bdi_eot(core_bdi_eot), .core_bdi_eoi(core_bdi_eoi),
        .core_bdi_ready(core_bdi_ready), .core_mode(core_mode), .core_bdo(core_bdo),
        .core_bdo_valid(core_bdo_valid), .core_bdo_type(core_bdo_type),
        .core_bdo_eot(core_bdo_eot), .core_bdo_ready(core_bdo_ready),
        .core_bdo_eoo(core_bdo_eoo), .core_auth(core_auth),
        .core_auth_valid(core_auth_valid), .core_done(core_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden output-word transform shared by the core stand-in and the scoreboard.
    function automatic logic [31:0] xf(input logic [31:0] k, input logic [31:0] d,
                                       input logic [3:0] m);
        return {d[15:0], d[31:16]} ^ k ^ (32'h9E3779B9 * {28'h0, m});
    endfunction

    function automatic logic [31:0] junk(input int r);
        return {16'hBAD0, 16'(r)};
    endfunction

    // ---------------- core stand-in ----------------
    typedef enum logic [2:0] {CIdle, CKey, CBdi, COut, CDone} cst_e;
    cst_e        cs;
    logic [31:0] ckey, cacc;
    logic [3:0]  cmode;
    logic [31:0] cbuf [16];
    int          cn, coi;
    logic        cauth;

    always @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            cs <= CIdle; cn <= 0; coi <= 0; cauth <= 1'b0; cacc <= '0;
            cmode <= '0; ckey <= '0;
        end else begin
            case (cs)
                CIdle: if (core_mode != 4'd0) begin
                    cmode <= core_mode; cs <= CKey; cn <= 0; coi <= 0; cacc <= '0;
                end
                CKey: if (core_key_valid) begin
                    ckey <= core_key; cs <= CBdi;
                end
                CBdi: if (core_bdi_valid != 4'd0) begin
                    if (core_bdi_eoi && cmode == M_DEC) begin
                        cauth <= (core_bdi == (cacc ^ ckey));
                        cs    <= COut;
                    end else begin
                        cbuf[cn] <= xf(ckey, core_bdi, cmode);
                        cn       <= cn + 1;
                        cacc     <= cacc ^ core_bdi;
                        if (core_bdi_eoi) cs <= COut;
                    end
                end
                COut: if (core_bdo_ready) begin
                    coi <= coi + 1;
                    if (coi == cn - 1) cs <= CDone;
                end
                default: cs <= CIdle;
            endcase
        end
    end

    assign core_key_ready  = (cs == CKey);
    assign core_bdi_ready  = (cs == CBdi);
    assign core_bdo_valid  = (cs == COut);
    assign core_bdo        = (cs == COut) ? cbuf[coi] : 32'h0;
    assign core_bdo_type   = (cs == COut) ? 4'h4 : 4'h0;
    assign core_bdo_eot    = (cs == COut) && (coi == cn - 1);
    assign core_done       = (cs == CDone);
    assign core_auth_valid = (cs == CDone) && (cmode == M_DEC);
    assign core_auth       = (cs == CDone) && (cmode == M_DEC) && cauth;

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [32:0] v);
        if (r == 0) sb0.push_back(v); else sb1.push_back(v);
    endtask

    // Output-stream scoreboard, isolation, mux-leak, done and mask monitors.
    always @(negedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (req_bdo_valid[r] && req_bdo_ready[r]) begin
                n_cmp++;
                assert (((r == 0) ? sb0.size() : sb1.size()) != 0) else begin
                    n_bad++;
                    $error("FAIL bdo_unexpected: observed word %0h on %0d expected none",
                           req_bdo[r], r);
                end
                if (((r == 0) ? sb0.size() : sb1.size()) != 0) begin
                    mon_exp = (r == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk("bdo_word", {31'b0, req_bdo_eot[r], req_bdo[r]}, {31'b0, mon_exp});
                end
            end
            if (!gnt[r] && (req_key_ready[r] || req_bdi_ready[r] || req_bdo_valid[r] ||
                            req_bdo[r] != 32'h0)) iso_bad++;
            if (req_done[r]) done_cnt[r]++;
        end
        if (gnt != 2'b00 && req_done == 2'b00) begin
            if ({core_mode, core_key, core_key_valid, core_bdi, core_bdi_valid, core_bdi_type,
                 core_bdi_eot, core_bdi_eoi, core_bdo_ready, core_bdo_eoo} !==
                {req_mode[gnt[1]], req_key[gnt[1]], req_key_valid[gnt[1]], req_bdi[gnt[1]],
                 req_bdi_valid[gnt[1]], req_bdi_type[gnt[1]], req_bdi_eot[gnt[1]],
                 req_bdi_eoi[gnt[1]], req_bdo_ready[gnt[1]], req_bdo_eoo[gnt[1]]})
                leak_bad++;
        end else if ({core_mode, core_key, core_key_valid, core_bdi, core_bdi_valid,
                      core_bdi_type, core_bdi_eot, core_bdi_eoi, core_bdo_ready,
                      core_bdo_eoo} !== '0) begin
            leak_bad++;
        end
        if (req_done != 2'b00 && req_done !== gnt) iso_bad++;
        if ((req_done & dn1) != 2'b00) iso_bad++;
        if ((gnt & dn2) != 2'b00) mask_bad++;
        if (gnt != 2'b00 && gprev == 2'b00) glog.push_back(gnt[1] ? 1 : 0);
        gprev <= gnt;
        dn1   <= req_done;
        dn2   <= dn1;
    end

    // ---------------- requester driver ----------------
    task automatic wait_rdy(input int r, input bit bdi);
        int t;
        t = 0;
        @(negedge clk);
        while (!(bdi ? req_bdi_ready[r] : req_key_ready[r]) && t < LIM) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        assert (t < LIM) else begin
            n_bad++;
            $error("FAIL ready_timeout: observed %0d cycles expected < %0d", t, LIM);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int r, input logic [3:0] mode, input logic [31:0] key,
                          input int nw, input logic [31:0] seed, input bit bad_tag,
                          input bit rnd);
        logic [31:0] acc, w;
        int          nt, t;
        bit          last;
        acc = '0;
        nt  = nw + ((mode == M_DEC) ? 1 : 0);
        @(posedge clk);
        #1;
        req_mode[r]      = mode;
        req_bdo_ready[r] = 1'b1;
        req_key[r]       = key;
        req_key_valid[r] = 1'b1;
        wait_rdy(r, 1'b0);
        req_key_valid[r] = 1'b0;
        req_key[r]       = junk(r);
        for (int i = 0; i < nt; i++) begin
            last = (i == nt - 1);
            if (i < nw) w = seed ^ (32'(i) * 32'h01000193);
            else        w = acc ^ key ^ {31'b0, bad_tag};
            req_bdi[r]       = w;
            req_bdi_valid[r] = 4'hF;
            req_bdi_type[r]  = (i < nw) ? 4'h1 : 4'h8;
            req_bdi_eot[r]   = last;
            req_bdi_eoi[r]   = last;
            wait_rdy(r, 1'b1);
            if (i < nw) begin
                push(r, {(i == nw - 1), xf(key, w, mode)});
                acc = acc ^ w;
            end
        end
        req_bdi[r] = junk(r); req_bdi_valid[r] = '0; req_bdi_type[r] = '0;
        req_bdi_eot[r] = 1'b0; req_bdi_eoi[r] = 1'b0;
        t = 0;
        while (t < LIM) begin
            @(negedge clk);
            if (req_done[r]) break;
            @(posedge clk);
            #1;
            if (rnd) req_bdo_ready[r] = 1'($urandom_range(0, 1));
            t++;
        end
        n_cmp++;
        assert (t < LIM) else begin
            n_bad++;
            $error("FAIL done_timeout: observed %0d cycles expected < %0d", t, LIM);
        end
        // Hold the request through the masked IDLE cycle, then drop it.
        @(posedge clk);
        @(posedge clk);
        #1;
        req_mode[r]      = 4'd0;
        req_bdo_ready[r] = 1'b0;
        chk("sb_drained", (r == 0) ? sb0.size() : sb1.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    int d0, t;

    initial begin
        done_cnt[0] = 0; done_cnt[1] = 0;
        rst_n = 1'b0;
        req_mode = '0; req_key_valid = '0; req_bdi_valid = '0; req_bdi_type = '0;
        req_bdi_eot = '0; req_bdi_eoi = '0; req_bdo_ready = '0; req_bdo_eoo = '0;
        for (int r = 0; r < 2; r++) begin
            req_key[r] = junk(r);
            req_bdi[r] = junk(r);
        end

        // Reset values and core_rst release timing.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_core_rst", core_rst, 1);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", req_done, 0);
        chk("rst_auth", {req_auth, req_auth_valid}, 0);
        chk("rst_ready", {req_key_ready, req_bdi_ready, req_bdo_valid}, 0);
        chk("rst_bdo", req_bdo, 0);
        chk("rst_core_mode", core_mode, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("core_rst_hold", core_rst, 1);
        @(posedge clk);
        @(negedge clk);
        chk("core_rst_fall", core_rst, 0);

        // Single encrypt on requester 0 with grant-latency checks.
        fork
            run_op(0, M_ENC, 32'h0123_4567, 8, 32'hA5A5_0000, 1'b0, 1'b0);
            begin
                @(posedge clk);
                #1;
                @(negedge clk);
                chk("lat_idle_gnt", gnt, 2'b00);
                @(negedge clk);
                chk("lat_start_gnt", gnt, 2'b01);
                chk("lat_start_mode", core_mode, M_ENC);
            end
        join
        chk("enc_done_cnt", done_cnt[0], 1);
        chk("enc_gnt_idle", gnt, 2'b00);

        // Concurrent decrypts: requester 1 with corrupted tag, requester 0 correct.
        glog.delete();
        fork
            run_op(1, M_DEC, 32'hCAFE_0001, 4, 32'h1111_0000, 1'b1, 1'b0);
            run_op(0, M_DEC, 32'hCAFE_0002, 4, 32'h2222_0000, 1'b0, 1'b0);
        join
        chk("dec_order_n", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("dec_order_0", glog[0], 1);
            chk("dec_order_1", glog[1], 0);
        end
        chk("auth_valid", req_auth_valid, 2'b11);
        chk("auth_value", req_auth, 2'b01);

        // Auth result persists until that requester's next START.
        fork
            run_op(1, M_ENC, 32'h0BAD_F00D, 3, 32'h3333_0000, 1'b0, 1'b0);
            begin
                @(posedge clk);
                #1;
                @(negedge clk);
                @(negedge clk);
                chk("persist_start", req_auth_valid, 2'b11);
                @(negedge clk);
                chk("persist_busy_v", req_auth_valid, 2'b01);
                chk("persist_busy_a", req_auth, 2'b01);
            end
        join
        chk("persist_after", {req_auth, req_auth_valid}, {2'b01, 2'b01});

        // Reset pulse in the middle of BUSY.
        @(posedge clk);
        #1;
        req_mode[1] = M_ENC; req_key[1] = 32'h5555_AAAA; req_key_valid[1] = 1'b1;
        t = 0;
        @(negedge clk);
        while (gnt != 2'b10 && t < LIM) begin
            @(negedge clk);
            t++;
        end
        chk("abort_granted", gnt, 2'b10);
        repeat (3) @(negedge clk);
        d0 = done_cnt[1];
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_outs", {req_key_ready, req_bdi_ready, req_bdo_valid, req_auth_valid}, 0);
        chk("abort_core_mode", core_mode, 0);
        req_mode[1] = 4'd0; req_key_valid[1] = 1'b0; req_key[1] = junk(1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt[1], d0);
        chk("abort_core_rst_rel", core_rst, 0);

        // Both requesters hold requests: grants alternate 0,1,0,1.
        glog.delete();
        fork
            begin
                run_op(0, M_ENC, 32'h1357_9BDF, 4, 32'h4444_0000, 1'b0, 1'b0);
                run_op(0, M_ENC, 32'h2468_ACE0, 3, 32'h5555_0000, 1'b0, 1'b0);
            end
            begin
                run_op(1, M_ENC, 32'h8642_0000, 5, 32'h6666_0000, 1'b0, 1'b0);
                run_op(1, M_ENC, 32'h9753_1111, 2, 32'h7777_0000, 1'b0, 1'b0);
            end
        join
        chk("rr_order_n", glog.size(), 4);
        if (glog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", glog[i], i % 2);
        end

        // Hash with random back-pressure, then back-to-back XOF from the same requester.
        d0 = done_cnt[0];
        run_op(0, M_HASH, 32'h0, 8, 32'h8888_0000, 1'b0, 1'b1);
        run_op(0, M_XOF, 32'h0, 8, 32'h9999_0000, 1'b0, 1'b1);
        chk("hash_xof_done", done_cnt[0], d0 + 2);
        repeat (4) @(negedge clk);
        chk("final_gnt", gnt, 0);

        chk("mask_regrant", mask_bad, 0);
        chk("isolation", iso_bad, 0);
        chk("core_mux", leak_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
